c3aibadapt_txasync_sr_sched: RTL and testbench
==============================================

Name: c3aibadapt_txasync_sr_sched

Overview:
- Fabric-side scheduler for the TX async shift-register update path. It shares the single load sequencer between a fast-SR requester (1-bit, e.g. txelecidle) and a slow-SR requester (36-bit control word).
- It drives the FSR/SSR data and load pulses consumed by the TX async update logic, with programmable setup/load/hold timing.
- After each update it compares the parity-checker readback against the driven value and flags mismatches.

Parameters:
- SSR_WIDTH, 36: slow-SR word width.
- SETUP_CYC, 2: cycles data is stable before load rises (>=1).
- LOAD_CYC, 2: load pulse width in cycles (>=1).
- HOLD_CYC, 2: cycles data is held after load falls (>=1).
- CHK_LAT, 4: check-window length in cycles; readback is compared on the last cycle (>=1).
- FSR_BURST_MAX, 4: maximum consecutive FSR grants while an SSR request is pending (>=1).

Ports:
- tx_clock_async_rx_osc_clk  in  1  sole clock.
- tx_reset_async_rx_osc_clk_rst  in  1  synchronous, active-high reset.
- r_tx_async_sr_sched_en  in  1  DPRIO enable; when low, no new requests are accepted.
- fsr_req_valid  in  1  FSR update request.
- fsr_req_data  in  1  FSR value.
- fsr_req_ready  out  1  FSR accept.
- ssr_req_valid  in  1  SSR update request.
- ssr_req_data  in  SSR_WIDTH  SSR value.
- ssr_req_ready  out  1  SSR accept.
- tx_async_fabric_hssi_fsr_data  out  1  FSR data to the update logic.
- tx_async_fabric_hssi_fsr_load  out  1  FSR load pulse.
- tx_async_fabric_hssi_ssr_data  out  SSR_WIDTH  SSR data to the update logic.
- tx_async_fabric_hssi_ssr_load  out  1  SSR load pulse.
- tx_fsr_parity_checker_in  in  1  FSR readback.
- tx_ssr_parity_checker_in  in  SSR_WIDTH  SSR readback.
- sr_chk_clr  in  1  clears sr_chk_err.
- sched_busy  out  1  high whenever state != IDLE.
- sr_chk_err  out  1  sticky readback-mismatch flag.

Behaviour:
- Reset: all outputs are 0, state is IDLE, fsr_streak is 0, and the selected-path register is cleared. Reset takes effect in any state, mid-sequence included, and the load pulse drops on the next edge.
- States: IDLE -> SETUP -> LOAD -> HOLD -> CHECK -> IDLE. A single down-counter is reloaded on each transition.
- Ready signals are combinational and independent of their own valid:
  - fsr_req_ready = IDLE & en & (!ssr_req_valid | fsr_streak<FSR_BURST_MAX)
  - ssr_req_ready = IDLE & en & (!fsr_req_valid | fsr_streak==FSR_BURST_MAX)
- Accept = valid & ready in cycle T. On accept, the path is recorded and the requester's data is registered onto its hssi data output, visible from T+1.
- Only the selected path's data and load change. The other path's data output keeps its last loaded value.
- Timing from an accept in cycle T:
  - SETUP: T+1 .. T+SETUP_CYC.
  - LOAD: the selected load is high for cycles T+SETUP_CYC+1 .. T+SETUP_CYC+LOAD_CYC.
  - HOLD: HOLD_CYC cycles.
  - CHECK: CHK_LAT cycles.
  - IDLE is re-entered at T+1+SETUP_CYC+LOAD_CYC+HOLD_CYC+CHK_LAT, which is T+11 with defaults. The next accept is possible in that cycle.
- Check: on the last CHECK cycle, compare the readback for the selected path against the driven data. A mismatch sets sr_chk_err. sr_chk_clr clears it; if set and clear occur in the same cycle, set wins.
- Streak:
  - An FSR grant while ssr_req_valid=1 increments fsr_streak, saturating at FSR_BURST_MAX.
  - An FSR grant with ssr_req_valid=0 resets it to 0.
  - Any SSR grant resets it to 0.
- Enable low: ready signals go low. An in-flight sequence runs to completion.
- Data inputs are ignored outside the accept cycle. Valid may drop without an accept; nothing is latched.
- Counter widths are $clog2 of the largest of the timing parameters, plus 1.

Test Plan:
- Reset, then FSR request data=1 at T=10 → fsr_data=1 from T=11; fsr_load high at T=13,14 only; ssr_load stays 0; sched_busy high T=11..20; fsr_req_ready high again at T=21.
- SSR request 36'h9_ABCD_1234 with readback tied equal → ssr_data updates at T+1; ssr_load pulse lasts 2 cycles; sr_chk_err stays 0. Repeat with readback bit 0 flipped → sr_chk_err=1 at T+11 and holds; sr_chk_clr pulse → 0.
- FSR and SSR both continuously valid from IDLE → grant order F,F,F,F,S,F,F,F,F,S; each grant spaced 11 cycles.
- Assert reset during the LOAD state of an SSR update → next cycle all loads 0, data outputs 0, state IDLE; a fresh FSR request completes normally afterward.
- en=0 with both valid → both ready signals stay 0 for 20 cycles. Drop en during SETUP → the sequence still completes and the load pulse is emitted.
- Mismatch in the CHECK cycle with sr_chk_clr asserted in the same cycle → sr_chk_err=1.

Source files
------------

// File: rtl/c3aibadapt_txasync_sr_sched.sv
// Scheduler for the TX async shift-register update path. It arbitrates one
// load sequencer between a fast-SR (1-bit) and a slow-SR (multi-bit) requester.
module c3aibadapt_txasync_sr_sched #(
    parameter int SSR_WIDTH     = 36,
    parameter int SETUP_CYC     = 2,
    parameter int LOAD_CYC      = 2,
    parameter int HOLD_CYC      = 2,
    parameter int CHK_LAT       = 4,
    parameter int FSR_BURST_MAX = 4
) (
    input  logic                 tx_clock_async_rx_osc_clk,
    input  logic                 tx_reset_async_rx_osc_clk_rst,
    input  logic                 r_tx_async_sr_sched_en,
    input  logic                 fsr_req_valid,
    input  logic                 fsr_req_data,
    output logic                 fsr_req_ready,
    input  logic                 ssr_req_valid,
    input  logic [SSR_WIDTH-1:0] ssr_req_data,
    output logic                 ssr_req_ready,
    output logic                 tx_async_fabric_hssi_fsr_data,
    output logic                 tx_async_fabric_hssi_fsr_load,
    output logic [SSR_WIDTH-1:0] tx_async_fabric_hssi_ssr_data,
    output logic                 tx_async_fabric_hssi_ssr_load,
    input  logic                 tx_fsr_parity_checker_in,
    input  logic [SSR_WIDTH-1:0] tx_ssr_parity_checker_in,
    input  logic                 sr_chk_clr,
    output logic                 sched_busy,
    output logic                 sr_chk_err
);

    localparam int MAX_SL = (SETUP_CYC > LOAD_CYC) ? SETUP_CYC : LOAD_CYC;
    localparam int MAX_HC = (HOLD_CYC > CHK_LAT) ? HOLD_CYC : CHK_LAT;
    localparam int MAX_T  = (MAX_SL > MAX_HC) ? MAX_SL : MAX_HC;
    localparam int CNT_W  = $clog2(MAX_T) + 1;
    localparam int STRK_W = $clog2(FSR_BURST_MAX + 1);

    localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  LOAD_LD   = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  CHK_LD    = CNT_W'(CHK_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [STRK_W-1:0] BURST_MAX = STRK_W'(FSR_BURST_MAX);
    localparam logic [STRK_W-1:0] STRK_ZERO = {STRK_W{1'b0}};
    localparam logic [STRK_W-1:0] STRK_ONE  = STRK_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  sel_r, sel_s;          // 1: slow-SR path selected
    logic [STRK_W-1:0]     streak_r, streak_s;
    logic                  fsr_data_r, fsr_data_s;
    logic                  fsr_load_r, fsr_load_s;
    logic [SSR_WIDTH-1:0]  ssr_data_r, ssr_data_s;
    logic                  ssr_load_r, ssr_load_s;
    logic                  err_r, err_s;
    logic                  idle_s, fsr_acc_s, ssr_acc_s, mismatch_s, chk_last_s;

    assign idle_s        = (state_r == ST_IDLE);
    assign fsr_req_ready = idle_s & r_tx_async_sr_sched_en & (~ssr_req_valid | (streak_r < BURST_MAX));
    assign ssr_req_ready = idle_s & r_tx_async_sr_sched_en & (~fsr_req_valid | (streak_r == BURST_MAX));
    assign fsr_acc_s     = fsr_req_valid & fsr_req_ready;
    assign ssr_acc_s     = ssr_req_valid & ssr_req_ready;

    assign mismatch_s = sel_r ? (tx_ssr_parity_checker_in != ssr_data_r)
                              : (tx_fsr_parity_checker_in != fsr_data_r);
    assign chk_last_s = (state_r == ST_CHECK) && (cnt_r == CNT_ZERO);

    assign tx_async_fabric_hssi_fsr_data = fsr_data_r;
    assign tx_async_fabric_hssi_fsr_load = fsr_load_r;
    assign tx_async_fabric_hssi_ssr_data = ssr_data_r;
    assign tx_async_fabric_hssi_ssr_load = ssr_load_r;
    assign sched_busy                    = ~idle_s;
    assign sr_chk_err                    = err_r;

    // Next-state, sequencing counter, grant bookkeeping and output updates.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        sel_s      = sel_r;
        streak_s   = streak_r;
        fsr_data_s = fsr_data_r;
        fsr_load_s = fsr_load_r;
        ssr_data_s = ssr_data_r;
        ssr_load_s = ssr_load_r;
        case (state_r)
            ST_IDLE: begin
                if (fsr_acc_s) begin
                    state_s    = ST_SETUP;
                    cnt_s      = SETUP_LD;
                    sel_s      = 1'b0;
                    fsr_data_s = fsr_req_data;
                    if (ssr_req_valid) begin
                        streak_s = (streak_r == BURST_MAX) ? streak_r : (streak_r + STRK_ONE);
                    end else begin
                        streak_s = STRK_ZERO;
                    end
                end else if (ssr_acc_s) begin
                    state_s    = ST_SETUP;
                    cnt_s      = SETUP_LD;
                    sel_s      = 1'b1;
                    ssr_data_s = ssr_req_data;
                    streak_s   = STRK_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s    = ST_LOAD;
                    cnt_s      = LOAD_LD;
                    fsr_load_s = ~sel_r;
                    ssr_load_s = sel_r;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_LOAD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s    = ST_HOLD;
                    cnt_s      = HOLD_LD;
                    fsr_load_s = 1'b0;
                    ssr_load_s = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_CHECK;
                    cnt_s   = CHK_LD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                cnt_s      = CNT_ZERO;
                fsr_load_s = 1'b0;
                ssr_load_s = 1'b0;
            end
        endcase
    end

    // Sticky readback-mismatch flag; a new mismatch outranks a same-cycle clear.
    always_comb begin
        err_s = err_r;
        if (chk_last_s && mismatch_s) begin
            err_s = 1'b1;
        end else if (sr_chk_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge tx_clock_async_rx_osc_clk) begin
        if (tx_reset_async_rx_osc_clk_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            sel_r      <= 1'b0;
            streak_r   <= STRK_ZERO;
            fsr_data_r <= 1'b0;
            fsr_load_r <= 1'b0;
            ssr_data_r <= {SSR_WIDTH{1'b0}};
            ssr_load_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sel_r      <= sel_s;
            streak_r   <= streak_s;
            fsr_data_r <= fsr_data_s;
            fsr_load_r <= fsr_load_s;
            ssr_data_r <= ssr_data_s;
            ssr_load_r <= ssr_load_s;
            err_r      <= err_s;
        end
    end

endmodule

// File: tb/tb_c3aibadapt_txasync_sr_sched.sv
// Bench for c3aibadapt_txasync_sr_sched: directed scenarios plus random traffic,
// checked against a cycle-count reference model with a load/check scoreboard.
module tb_c3aibadapt_txasync_sr_sched;

    localparam int W = 36;
    localparam int S = 2;
    localparam int L = 2;
    localparam int H = 2;
    localparam int C = 4;
    localparam int B = 4;
    localparam int N = S + L + H + C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, fv, fd, sv, clr, frb;
    logic [W-1:0] sd, srb;
    logic         fr, sr, fo, fl, sl, busy, err;
    logic [W-1:0] so;

    c3aibadapt_txasync_sr_sched #(
        .SSR_WIDTH(W), .SETUP_CYC(S), .LOAD_CYC(L), .HOLD_CYC(H),
        .CHK_LAT(C), .FSR_BURST_MAX(B)
    ) dut (
        .tx_clock_async_rx_osc_clk     (clk),
        .tx_reset_async_rx_osc_clk_rst (rst),
        .r_tx_async_sr_sched_en        (en),
        .fsr_req_valid                 (fv),
        .fsr_req_data                  (fd),
        .fsr_req_ready                 (fr),
        .ssr_req_valid                 (sv),
        .ssr_req_data                  (sd),
        .ssr_req_ready                 (sr),
        .tx_async_fabric_hssi_fsr_data (fo),
        .tx_async_fabric_hssi_fsr_load (fl),
        .tx_async_fabric_hssi_ssr_data (so),
        .tx_async_fabric_hssi_ssr_load (sl),
        .tx_fsr_parity_checker_in      (frb),
        .tx_ssr_parity_checker_in      (srb),
        .sr_chk_clr                    (clr),
        .sched_busy                    (busy),
        .sr_chk_err                    (err)
    );

    typedef struct {
        bit           path;
        logic [W-1:0] data;
        int           rise;
    } exp_t;

    exp_t ld_q[$];
    bit   eq[$];
    bit   grant_log[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    int           busy_left = 0;
    int           streak = 0;
    bit           m_err = 1'b0;
    logic         m_fh = 1'b0;
    logic [W-1:0] m_sh = '0;
    bit           m_sel = 1'b0;
    bit           ever_rst = 1'b0;
    bit           mon_en = 1'b0;

    // stimulus for the next cycle
    bit           n_rst = 1'b0, n_en = 1'b1, n_fv = 1'b0, n_fd = 1'b0, n_sv = 1'b0;
    bit           n_clr = 1'b0, n_cor = 1'b0;
    logic [W-1:0] n_sd = '0;
    bit           acc_f, acc_s;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit idle, efr, esr, af, as_, mm;
        @(posedge clk);
        #2;
        rst = n_rst; en = n_en; fv = n_fv; fd = n_fd; sv = n_sv; sd = n_sd; clr = n_clr;
        frb = m_fh ^ (n_cor && !m_sel);
        srb = m_sh ^ {{(W-1){1'b0}}, (n_cor && m_sel)};
        mon_en = !n_rst;
        #1;
        idle = (busy_left == 0);
        efr = idle && n_en && (!n_sv || streak < B);
        esr = idle && n_en && (!n_fv || streak == B);
        if (ever_rst) begin
            chk("fsr_ready", fr, efr);
            chk("ssr_ready", sr, esr);
            chk("busy", busy, !idle);
            chk("chk_err", err, m_err);
            chk("fsr_data", fo, m_fh);
            chk("ssr_data", so, m_sh);
        end
        af = 1'b0;
        as_ = 1'b0;
        if (n_rst) begin
            busy_left = 0; streak = 0; m_err = 1'b0; m_fh = 1'b0; m_sh = '0; m_sel = 1'b0;
            ld_q.delete();
            eq.delete();
            ever_rst = 1'b1;
        end else begin
            if (busy_left == 1) begin
                mm = m_sel ? (srb !== m_sh) : (frb !== m_fh);
                if (mm) m_err = 1'b1;
                else if (n_clr) m_err = 1'b0;
                eq.push_back(m_err);
            end else if (n_clr) begin
                m_err = 1'b0;
            end
            af = n_fv && efr;
            as_ = n_sv && esr;
            if (af) begin
                m_fh = n_fd; m_sel = 1'b0;
                streak = n_sv ? ((streak < B) ? streak + 1 : B) : 0;
                ld_q.push_back('{1'b0, {{(W-1){1'b0}}, n_fd}, cyc + S + 1});
                busy_left = N;
            end else if (as_) begin
                m_sh = n_sd; m_sel = 1'b1; streak = 0;
                ld_q.push_back('{1'b1, n_sd, cyc + S + 1});
                busy_left = N;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
        acc_f = af;
        acc_s = as_;
    endtask

    task automatic idle_steps(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic req_f(bit d);
        bit got;
        got = 1'b0;
        n_fv = 1'b1; n_fd = d;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = acc_f;
        end
        n_fv = 1'b0;
        if (!got) chk("fsr_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic req_s(logic [W-1:0] d);
        bit got;
        got = 1'b0;
        n_sv = 1'b1; n_sd = d;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = acc_s;
        end
        n_sv = 1'b0;
        if (!got) chk("ssr_accept_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: matches each load pulse and each return to idle against the scoreboard.
    bit   pfl = 1'b0, psl = 1'b0, pb = 1'b0;
    int   lc = 0;
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pfl = 1'b0; psl = 1'b0; pb = 1'b0; lc = 0;
            end else begin
                if ((fl && !pfl) || (sl && !psl)) begin
                    if (ld_q.size() == 0) begin
                        chk("spurious_load", 64'd1, 64'd0);
                    end else begin
                        e = ld_q.pop_front();
                        chk("load_single", {63'd0, fl && sl}, 64'd0);
                        chk("load_path", {63'd0, sl}, {63'd0, e.path});
                        chk("load_cycle", 64'(cyc), 64'(e.rise));
                        chk("load_data", e.path ? 64'(so) : 64'(fo), 64'(e.data));
                        grant_log.push_back(sl);
                    end
                end
                if (fl || sl) lc++;
                if ((pfl && !fl) || (psl && !sl)) begin
                    chk("load_width", 64'(lc), 64'(L));
                    lc = 0;
                end
                if (pb && !busy) begin
                    if (eq.size() == 0) chk("spurious_idle", 64'd1, 64'd0);
                    else chk("check_err", {63'd0, err}, {63'd0, eq.pop_front()});
                end
                pfl = fl; psl = sl; pb = busy;
            end
        end
    end

    bit exp_pat[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b0; fv = 1'b0; fd = 1'b0; sv = 1'b0; sd = '0;
        clr = 1'b0; frb = 1'b0; srb = '0;

        n_rst = 1'b1;
        idle_steps(3);
        n_rst = 1'b0;
        idle_steps(4);

        // single FSR update
        req_f(1'b1);
        idle_steps(N + 2);

        // SSR update, clean then corrupted readback, then clear
        req_s(36'h9_ABCD_1234);
        idle_steps(N + 2);
        n_cor = 1'b1;
        req_s(36'h9_ABCD_1234);
        idle_steps(N + 4);
        n_cor = 1'b0;
        n_clr = 1'b1;
        step();
        n_clr = 1'b0;
        idle_steps(3);

        // both requesters continuously valid: burst-limited arbitration
        grant_log.delete();
        n_fv = 1'b1; n_sv = 1'b1;
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) begin
            n_fd = 1'($urandom); n_sd = {4'($urandom), 32'($urandom)};
            step();
        end
        n_fv = 1'b0; n_sv = 1'b0;
        idle_steps(N + 2);
        chk("grant_count", 64'(grant_log.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) chk("grant_order", {63'd0, grant_log[i]}, {63'd0, exp_pat[i]});

        // reset during the LOAD phase of an SSR update
        req_s(36'hF_0F0F_A5A5);
        idle_steps(S);
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        step();
        req_f(1'b1);
        idle_steps(N + 2);

        // enable low blocks new requests; dropping it mid-sequence does not abort
        n_en = 1'b0; n_fv = 1'b1; n_sv = 1'b1;
        idle_steps(20);
        n_en = 1'b1; n_fv = 1'b0; n_sv = 1'b0;
        step();
        req_f(1'b0);
        n_en = 1'b0;
        idle_steps(N + 2);
        n_en = 1'b1;

        // mismatch on the last check cycle with a simultaneous clear
        n_cor = 1'b1; n_clr = 1'b1;
        req_f(1'b1);
        idle_steps(N + 2);
        n_cor = 1'b0; n_clr = 1'b0;
        idle_steps(2);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            n_en  = ($urandom_range(7) != 0);
            n_fv  = 1'($urandom);
            n_fd  = 1'($urandom);
            n_sv  = 1'($urandom);
            n_sd  = {4'($urandom), 32'($urandom)};
            n_clr = ($urandom_range(15) == 0);
            n_cor = ($urandom_range(3) == 0);
            n_rst = ($urandom_range(199) == 0);
            step();
        end
        n_fv = 1'b0; n_sv = 1'b0; n_rst = 1'b0; n_clr = 1'b0; n_cor = 1'b0; n_en = 1'b1;
        idle_steps(N + 4);
        chk("load_queue_drained", 64'(ld_q.size()), 64'd0);
        chk("check_queue_drained", 64'(eq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
